// File: rtl/expr_string_tx.sv
// Transmit side of the ASCII expression stream: grammar check, ASCII translation, FIFO, char output.
// Optional newline terminator after each expression: define EXPR_STRING_TX_TERM_EN.
module expr_string_tx #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       tok_valid,
   output logic       tok_ready,
   input  logic       tok_is_op,
   input  logic [3:0] tok_val,
   input  logic       tok_last,
   output logic [7:0] ch,
   output logic       ch_valid,
   input  logic       ch_ready,
   output logic       ch_last,
   output logic       err
);

   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 9;

   typedef enum logic {
      EXP_DIGIT = 1'b0,
      EXP_OP    = 1'b1
   } gstate_t;

   gstate_t          state, state_d;
   logic [EW-1:0]    mem   [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr, wr_ptr_d;
   logic [AW-1:0]    rd_ptr, rd_ptr_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic             tok_ready_d;
   logic [7:0]       ch_d;
   logic             ch_valid_d;
   logic             ch_last_d;
   logic             err_d;

   logic             accept;
   logic             legal;
   logic             push;
   logic             pop_req;
   logic             fifo_pop;
   logic [EW-1:0]    push_data;
   logic [EW-1:0]    head_d;
`ifdef EXPR_STRING_TX_TERM_EN
   logic             nl_pend, nl_pend_d;
`endif

   // Next-state: grammar FSM, FIFO bookkeeping and the registered output stage
   always_comb begin
      state_d     = state;
      mem_d       = mem;
      wr_ptr_d    = wr_ptr;
      rd_ptr_d    = rd_ptr;
      cnt_d       = cnt;
      err_d       = 1'b0;
      legal       = 1'b0;
      push        = 1'b0;
      push_data   = '0;
      head_d      = '0;
      ch_d        = 8'd0;
      ch_valid_d  = 1'b0;
      ch_last_d   = 1'b0;
      accept      = tok_valid && tok_ready;
      pop_req     = ch_valid && ch_ready;
      fifo_pop    = pop_req;
`ifdef EXPR_STRING_TX_TERM_EN
      nl_pend_d   = nl_pend;
      fifo_pop    = pop_req && !nl_pend;
`endif

      unique case (state)
         EXP_DIGIT: begin
            legal     = !tok_is_op && (tok_val <= 4'd9);
            push_data = {8'd48 + {4'd0, tok_val}, tok_last};
         end
         EXP_OP: begin
            legal     = tok_is_op && (tok_val <= 4'd1) && !tok_last;
            push_data = {(tok_val[0] ? 8'd42 : 8'd43), 1'b0};
         end
         default: ;
      endcase

      if (accept) begin
         if (legal) begin
            push = 1'b1;
            if (state == EXP_DIGIT) state_d = tok_last ? EXP_DIGIT : EXP_OP;
            else                    state_d = EXP_DIGIT;
         end else begin
            err_d = 1'b1;
         end
      end

`ifdef EXPR_STRING_TX_TERM_EN
      // Popping an expression's final character arms the newline beat; popping the newline clears it
      if (nl_pend) begin
         if (pop_req) nl_pend_d = 1'b0;
      end else if (fifo_pop && mem[rd_ptr][0]) begin
         nl_pend_d = 1'b1;
      end
`endif

      if (fifo_pop) rd_ptr_d = rd_ptr + AW'(1);
      if (push) begin
         mem_d[wr_ptr] = push_data;
         wr_ptr_d      = wr_ptr + AW'(1);
      end

      unique case ({push, fifo_pop})
         2'b10:   cnt_d = cnt + CW'(1);
         2'b01:   cnt_d = cnt - CW'(1);
         default: cnt_d = cnt;
      endcase

      tok_ready_d = (cnt_d < CW'(DEPTH));
      head_d      = mem_d[rd_ptr_d];

`ifdef EXPR_STRING_TX_TERM_EN
      if (nl_pend_d) begin
         ch_d       = 8'd10;
         ch_valid_d = 1'b1;
         ch_last_d  = 1'b1;
      end else if (cnt_d != '0) begin
         ch_d       = head_d[EW-1:1];
         ch_valid_d = 1'b1;
         ch_last_d  = 1'b0;
      end
`else
      if (cnt_d != '0) begin
         ch_d       = head_d[EW-1:1];
         ch_valid_d = 1'b1;
         ch_last_d  = head_d[0];
      end
`endif
   end

   // State register
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= EXP_DIGIT;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         tok_ready <= 1'b1;
         ch        <= 8'd0;
         ch_valid  <= 1'b0;
         ch_last   <= 1'b0;
         err       <= 1'b0;
`ifdef EXPR_STRING_TX_TERM_EN
         nl_pend   <= 1'b0;
`endif
      end else begin
         state     <= state_d;
         mem       <= mem_d;
         wr_ptr    <= wr_ptr_d;
         rd_ptr    <= rd_ptr_d;
         cnt       <= cnt_d;
         tok_ready <= tok_ready_d;
         ch        <= ch_d;
         ch_valid  <= ch_valid_d;
         ch_last   <= ch_last_d;
         err       <= err_d;
`ifdef EXPR_STRING_TX_TERM_EN
         nl_pend   <= nl_pend_d;
`endif
      end
   end

endmodule
